// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbiter sharing one single-ported unified memory between the
//               Fetch stage (instruction reads) and the Memory stage
//               (loads/stores). One bus transaction at a time; data requests
//               normally win, but a pending fetch is forced through after
//               MAX_WAIT consecutive data grants. A taken jump (flush) kills
//               the outstanding fetch without aborting the bus transaction.
// Ports       :
//   clk, reset          - clock, synchronous active-high reset
//   flush               - taken jump, kills the outstanding fetch
//   if_req/if_addr      - fetch request (level, held until if_ready)
//   if_rdata/if_ready   - instruction and one-cycle completion pulse
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata - data request (held until dm_ready)
//   dm_rdata/dm_ready   - load data and one-cycle completion pulse
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata - registered memory request
//   mem_rdata/mem_ack   - memory read data and completion
//   stall_F, stall_M    - stalls to the hazard unit
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                stall_F,
    output logic                stall_M
);

    localparam int         c_BE_W     = DATA_W / 8;
    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_IF   = 2'd1,
        BUSY_DM   = 2'd2,
        BUSY_DROP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_starve_cnt;
    logic [3:0]          w_starve_nxt;
    logic                w_req_nxt;
    logic                w_we_nxt;
    logic [c_BE_W-1:0]   w_be_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic                w_if_ready;
    logic                w_dm_ready;
    logic                w_fetch_wins;

    // Fetch wins when it is alone, or when it has been starved long enough.
    assign w_fetch_wins = if_req && (!dm_req || (r_starve_cnt == c_MAX_WAIT));

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_req_nxt    = mem_req;
        w_we_nxt     = mem_we;
        w_be_nxt     = mem_be;
        w_addr_nxt   = mem_addr;
        w_wdata_nxt  = mem_wdata;
        w_if_ready   = 1'b0;
        w_dm_ready   = 1'b0;

        case (r_state)
            IDLE: begin
                if (!if_req) begin
                    w_starve_nxt = 4'd0;
                end
                if (w_fetch_wins) begin
                    w_state_nxt  = BUSY_IF;
                    w_starve_nxt = 4'd0;
                    w_req_nxt    = 1'b1;
                    w_we_nxt     = 1'b0;
                    w_be_nxt     = {c_BE_W{1'b1}};
                    w_addr_nxt   = if_addr;
                    w_wdata_nxt  = '0;
                end else if (dm_req) begin
                    w_state_nxt  = BUSY_DM;
                    w_req_nxt    = 1'b1;
                    w_we_nxt     = dm_we;
                    w_be_nxt     = dm_be;
                    w_addr_nxt   = dm_addr;
                    w_wdata_nxt  = dm_wdata;
                    // Count data grants that overtook a waiting fetch.
                    if (if_req && (r_starve_cnt != 4'hF)) begin
                        w_starve_nxt = r_starve_cnt + 4'd1;
                    end
                end
            end
            BUSY_IF: begin
                if (mem_ack) begin
                    // A same-cycle flush swallows the completing fetch.
                    w_if_ready  = !flush;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else if (flush) begin
                    // The bus access cannot be aborted; let it drain silently.
                    w_state_nxt = BUSY_DROP;
                end
            end
            BUSY_DM: begin
                if (mem_ack) begin
                    w_dm_ready  = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            BUSY_DROP: begin
                if (mem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= 4'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            mem_req      <= w_req_nxt;
            mem_we       <= w_we_nxt;
            mem_be       <= w_be_nxt;
            mem_addr     <= w_addr_nxt;
            mem_wdata    <= w_wdata_nxt;
        end
    end

    assign if_ready = w_if_ready && !reset;
    assign dm_ready = w_dm_ready && !reset;
    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;
    assign stall_F  = !reset && if_req && !w_if_ready;
    assign stall_M  = !reset && dm_req && !w_dm_ready;

endmodule
`default_nettype wire
